rtc_bus_sequencer: RTL

- Sequences single-byte read/write transactions on the multiplexed address/data bus of the real-time clock on behalf of the PicoBlaze port logic.
- Each transaction has two phases: an address phase, then a data phase.
- Sits between the PicoBlaze port decode and the RTC pins.
- Moves raw BCD register bytes only; BCD/binary conversion happens outside this block.

---
 rtl/rtc_bus_sequencer_pkg.sv | 32 +++
 rtl/rtc_phase_timer.sv | 34 +++
 rtl/rtc_bus_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/rtc_bus_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// rtc_bus_sequencer_pkg : state encoding and timing defaults for the RTC bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rtc_bus_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_A_SETUP  = 4'd1,
    ST_A_STROBE = 4'd2,
    ST_A_HOLD   = 4'd3,
    ST_GAP      = 4'd4,
    ST_D_SETUP  = 4'd5,
    ST_D_STROBE = 4'd6,
    ST_D_HOLD   = 4'd7,
    ST_DONE     = 4'd8
  } state_t;

  localparam int c_t_setup_def  = 2;
  localparam int c_t_strobe_def = 4;
  localparam int c_t_hold_def   = 2;
  localparam int c_t_gap_def    = 4;
  localparam int c_cnt_w_def    = 8;

  localparam logic c_ad_sel_addr = 1'b0;
  localparam logic c_ad_sel_data = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rtc_phase_timer.sv
// ---------------------------------------------------------------------------
// rtc_phase_timer : loadable down-counter that flags expiry at zero
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rtc_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] r_cnt;

  // Saturates at zero so a state held past expiry never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign expire = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/rtc_bus_sequencer.sv
// ---------------------------------------------------------------------------
// rtc_bus_sequencer : address/data phase sequencer for the RTC multiplexed bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rtc_bus_sequencer
  import rtc_bus_sequencer_pkg::*;
#(
  parameter int T_SETUP  = c_t_setup_def,
  parameter int T_STROBE = c_t_strobe_def,
  parameter int T_HOLD   = c_t_hold_def,
  parameter int T_GAP    = c_t_gap_def,
  parameter int CNT_W    = c_cnt_w_def
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad_sel,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  localparam logic [CNT_W-1:0] c_ld_setup  = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] c_ld_strobe = CNT_W'(T_STROBE - 1);
  localparam logic [CNT_W-1:0] c_ld_hold   = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] c_ld_gap    = CNT_W'(T_GAP - 1);

  state_t           r_state, w_state_n;
  logic             r_rw, w_rw_n;
  logic [7:0]       r_addr, w_addr_n;
  logic [7:0]       r_wdata, w_wdata_n;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_expire;

  logic             w_busy, w_done, w_cs_n, w_rd_n, w_wr_n, w_ad_sel, w_ad_oe;
  logic [7:0]       w_ad_out;

  rtc_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .load_val (w_load_val),
    .expire   (w_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_rw    <= 1'b0;
      r_addr  <= 8'h00;
      r_wdata <= 8'h00;
    end else begin
      r_state <= w_state_n;
      r_rw    <= w_rw_n;
      r_addr  <= w_addr_n;
      r_wdata <= w_wdata_n;
    end
  end

  // Next state; the timer is reloaded on every entry into a timed state.
  always_comb begin
    w_state_n  = r_state;
    w_rw_n     = r_rw;
    w_addr_n   = r_addr;
    w_wdata_n  = r_wdata;
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_n  = ST_A_SETUP;
          w_rw_n     = rw;
          w_addr_n   = addr;
          w_wdata_n  = wdata;
          w_load     = 1'b1;
          w_load_val = c_ld_setup;
        end
      end
      ST_A_SETUP: if (w_expire) begin
        w_state_n = ST_A_STROBE; w_load = 1'b1; w_load_val = c_ld_strobe;
      end
      ST_A_STROBE: if (w_expire) begin
        w_state_n = ST_A_HOLD; w_load = 1'b1; w_load_val = c_ld_hold;
      end
      ST_A_HOLD: if (w_expire) begin
        w_state_n = ST_GAP; w_load = 1'b1; w_load_val = c_ld_gap;
      end
      ST_GAP: if (w_expire) begin
        w_state_n = ST_D_SETUP; w_load = 1'b1; w_load_val = c_ld_setup;
      end
      ST_D_SETUP: if (w_expire) begin
        w_state_n = ST_D_STROBE; w_load = 1'b1; w_load_val = c_ld_strobe;
      end
      ST_D_STROBE: if (w_expire) begin
        w_state_n = ST_D_HOLD; w_load = 1'b1; w_load_val = c_ld_hold;
      end
      ST_D_HOLD: if (w_expire) w_state_n = ST_DONE;
      ST_DONE:   w_state_n = ST_IDLE;
      default:   w_state_n = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up
  // with the state they belong to.
  always_comb begin
    w_busy   = 1'b0;
    w_done   = 1'b0;
    w_cs_n   = 1'b1;
    w_rd_n   = 1'b1;
    w_wr_n   = 1'b1;
    w_ad_sel = c_ad_sel_addr;
    w_ad_out = 8'h00;
    w_ad_oe  = 1'b0;
    case (w_state_n)
      ST_A_SETUP, ST_A_STROBE, ST_A_HOLD, ST_GAP: begin
        w_busy   = 1'b1;
        w_cs_n   = 1'b0;
        w_ad_out = w_addr_n;
        w_ad_oe  = 1'b1;
        w_wr_n   = (w_state_n != ST_A_STROBE);
      end
      ST_D_SETUP, ST_D_STROBE, ST_D_HOLD: begin
        w_busy   = 1'b1;
        w_cs_n   = 1'b0;
        w_ad_sel = c_ad_sel_data;
        if (w_rw_n) begin
          w_rd_n = (w_state_n != ST_D_STROBE);
        end else begin
          w_ad_out = w_wdata_n;
          w_ad_oe  = 1'b1;
          w_wr_n   = (w_state_n != ST_D_STROBE);
        end
      end
      ST_DONE: w_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      cs_n   <= 1'b1;
      rd_n   <= 1'b1;
      wr_n   <= 1'b1;
      ad_sel <= c_ad_sel_addr;
      ad_out <= 8'h00;
      ad_oe  <= 1'b0;
    end else begin
      busy   <= w_busy;
      done   <= w_done;
      cs_n   <= w_cs_n;
      rd_n   <= w_rd_n;
      wr_n   <= w_wr_n;
      ad_sel <= w_ad_sel;
      ad_out <= w_ad_out;
      ad_oe  <= w_ad_oe;
    end
  end

  // Read data is taken on the edge where rd_n releases.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= 8'h00;
    end else if (r_state == ST_D_STROBE && w_expire && r_rw) begin
      rdata <= ad_in;
    end
  end

endmodule

`default_nettype wire
